// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 16-to-1 selector through all inputs and assembles the returned bits into a word
module mux_scan_ctrl (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic        Abort,
  input  logic        f,
  output logic [3:0]  S,
  output logic [15:0] Q,
  output logic        Busy,
  output logic        Done
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] s_q, s_d;
  logic [15:0] cap_q, cap_d, q_q, q_d;
  // next state: f is captured at index S on the edge that advances S; Q publishes only on entry to DONE
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    cap_d = cap_q;
    q_d = q_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = Start ? SCAN : IDLE;
        s_d = Start ? 4'd0 : s_q;
        cap_d = Start ? 16'h0000 : cap_q;
      end
      SCAN: begin
        if (Abort) begin
          state_d = IDLE;
          s_d = 4'd0;
        end else begin
          cap_d[s_q] = f;
          s_d = s_q + 4'd1;
          if (s_q == 4'd15) begin
            state_d = DONE;
            q_d = cap_d;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous active-low reset taking priority over everything
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      s_q <= 4'd0;
      cap_q <= 16'h0000;
      q_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      cap_q <= cap_d;
      q_q <= q_d;
    end
  end
  assign S = s_q;
  assign Q = q_q;
  assign Busy = (state_q == SCAN);
  assign Done = (state_q == DONE);
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench; expected words and Done cycles are queued by stimulus and checked by a Done monitor
module tb_mux_scan_ctrl;
  logic Clock = 1'b0;
  logic Resetn, Start, Abort, f;
  logic [3:0] S;
  logic [15:0] Q, W, q_last;
  logic Busy, Done;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {logic [15:0] w; int c;} exp_t;
  exp_t sb[$];
  exp_t m_e;

  mux_scan_ctrl dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Abort(Abort), .f(f),
    .S(S), .Q(Q), .Busy(Busy), .Done(Done)
  );

  assign f = W[S];
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // monitor: every Done pulse must match the oldest expected completion, both word and cycle
  always @(negedge Clock) begin
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: Done=1 with no scan pending at cycle %0d (Q=%0h)", cyc, Q);
      end else begin
        m_e = sb.pop_front();
        check("done_q", Q, m_e.w);
        check("done_cycle", cyc, m_e.c);
      end
    end
  end

  // kind: 0 complete, 1 abort at kill_at, 2 abort+start at kill_at, 3 reset at kill_at
  task automatic do_scan(input logic [15:0] w, input int kill_at, input int kind, input bit repulse);
    int e;
    W = w;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    e = cyc;
    if (kind == 0) sb.push_back('{w, e + 16});
    for (int i = 0; i < 16; i++) begin
      check("scan_busy", Busy, 1);
      check("scan_s", S, i);
      if (kind != 0 && i == kill_at) begin
        if (kind == 3) begin
          Resetn = 1'b0;
          tick();
          check("rst_s", S, 0);
          check("rst_q", Q, 0);
          check("rst_busy", Busy, 0);
          check("rst_done", Done, 0);
          q_last = 16'h0000;
          Resetn = 1'b1;
        end else begin
          Abort = 1'b1;
          Start = (kind == 2);
          tick();
          Abort = 1'b0;
          check("abort_s", S, 0);
          check("abort_busy", Busy, 0);
          check("abort_q", Q, q_last);
        end
        return;
      end
      if (repulse && (i == 3 || i == 15 || $urandom_range(0, 3) == 0)) Start = 1'b1;
      tick();
      Start = 1'b0;
    end
    check("done_flag", Done, 1);
    check("done_busy", Busy, 0);
    check("done_q_now", Q, w);
    q_last = w;
    tick();
    check("idle_busy", Busy, 0);
    check("idle_done", Done, 0);
  endtask

  task automatic back_to_back(input logic [15:0] w1, input logic [15:0] w2);
    int e;
    W = w1;
    Start = 1'b1;
    tick();
    e = cyc;
    sb.push_back('{w1, e + 16});
    sb.push_back('{w2, e + 33});
    for (int i = 0; i < 16; i++) begin
      check("b2b_busy1", Busy, 1);
      check("b2b_s1", S, i);
      tick();
    end
    check("b2b_done1", Done, 1);
    check("b2b_busy_gap", Busy, 0);
    W = w2;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("b2b_busy2", Busy, 1);
      check("b2b_s2", S, i);
      tick();
    end
    check("b2b_done2", Done, 1);
    q_last = w2;
    tick();
    check("b2b_idle", Busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d scans pending", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    int r, kind;
    Resetn = 1'b0;
    Start = 1'b1;
    Abort = 1'b1;
    W = 16'h0000;
    q_last = 16'h0000;
    repeat (3) tick();
    check("reset_s", S, 0);
    check("reset_q", Q, 0);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    Start = 1'b0;
    Abort = 1'b0;
    Resetn = 1'b1;
    tick();
    do_scan(16'hA5C3, 0, 0, 1'b0);
    back_to_back(16'hFFFF, 16'h0001);
    do_scan(16'h1234, 0, 0, 1'b0);
    do_scan(16'hFFFF, 7, 1, 1'b0);
    repeat (3) tick();
    check("post_abort_q", Q, 16'h1234);
    do_scan(16'h00FF, 9, 3, 1'b0);
    do_scan(16'h00FF, 0, 0, 1'b0);
    do_scan(16'h8001, 0, 0, 1'b1);
    do_scan(16'h7777, 5, 2, 1'b0);
    do_scan(16'h3C5A, 0, 0, 1'b0);
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      kind = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      do_scan(16'($urandom), $urandom_range(0, 15), kind, 1'($urandom_range(0, 1)));
      if (kind != 2) begin
        repeat ($urandom_range(0, 2)) begin
          Abort = 1'($urandom_range(0, 1));
          tick();
          check("gap_busy", Busy, 0);
        end
        Abort = 1'b0;
      end
    end
    Start = 1'b0;
    repeat (20) tick();
    check("sb_empty", sb.size(), 0);
    check("final_q", Q, q_last);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
